// File: rtl/uart_dmi_bridge.sv
// uart_dmi_bridge: UART (8N1) to RISC-V DMI register bridge.
// Host commands: 0xFF = DMI hard reset, 1aaaaaaa + 4 data bytes (LE) = write,
// 0aaaaaaa = read (reply 4 bytes LE). Writes and hard reset reply with 0x00.
// Optional build macro: UART_DMI_TIMEOUT_EN enables the inter-byte timeout
// that drops a partially received write frame.
module uart_dmi_bridge #(
  parameter int CLKS_PER_BIT   = 434,
  parameter int TIMEOUT_CYCLES = 5000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_uart_rx,
  output logic        o_uart_tx,
  output logic        o_dmi_reg_en,
  output logic [6:0]  o_dmi_reg_addr,
  output logic        o_dmi_reg_wr_en,
  output logic [31:0] o_dmi_reg_wdata,
  input  logic [31:0] i_dmi_reg_rdata,
  output logic        o_dmi_hard_reset
);

  localparam logic [15:0] BIT_RELOAD  = 16'(CLKS_PER_BIT - 1);
  localparam logic [15:0] HALF_RELOAD = 16'(CLKS_PER_BIT / 2 - 1);

  // Reject parameter values the counters cannot represent.
  if (CLKS_PER_BIT < 4 || CLKS_PER_BIT > 65535 || TIMEOUT_CYCLES < 1) begin : g_bad_param
    $error("uart_dmi_bridge: illegal CLKS_PER_BIT or TIMEOUT_CYCLES");
  end

  // ---------------------------------------------------------------------
  // Reset: asserts asynchronously, releases two clk edges after rst falls.
  // ---------------------------------------------------------------------
  logic [1:0] rst_pipe_q;
  logic       rst_int;

  // Reset release synchronizer; every other register resets from rst_int.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rst_pipe_q <= 2'b11;
    else     rst_pipe_q <= {rst_pipe_q[0], 1'b0};
  end

  assign rst_int = rst_pipe_q[1];

  // ---------------------------------------------------------------------
  // UART receiver
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    RX_IDLE, RX_START, RX_DATA, RX_STOP, RX_WAIT_HIGH
  } rx_state_t;

  rx_state_t   rx_state_q;
  logic [1:0]  rx_sync_q;
  logic        rx_prev_q;
  logic [15:0] rx_cnt_q;
  logic [2:0]  rx_idx_q;
  logic [7:0]  rx_shift_q;
  logic [7:0]  rx_byte_q;
  logic        rx_valid_q;
  logic        rx_ferr_q;
  logic        rx_start_q;
  logic        rx_line;

  assign rx_line = rx_sync_q[1];

  // Synchronize the line, find the start edge and sample bits at their centres.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      rx_state_q <= RX_IDLE;
      rx_sync_q  <= 2'b11;
      rx_prev_q  <= 1'b1;
      rx_cnt_q   <= '0;
      rx_idx_q   <= '0;
      rx_shift_q <= '0;
      rx_byte_q  <= '0;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_start_q <= 1'b0;
    end else begin
      rx_sync_q  <= {rx_sync_q[0], i_uart_rx};
      rx_prev_q  <= rx_line;
      rx_valid_q <= 1'b0;
      rx_ferr_q  <= 1'b0;
      rx_start_q <= 1'b0;
      case (rx_state_q)
        RX_IDLE: begin
          if (rx_prev_q && !rx_line) begin
            rx_state_q <= RX_START;
            rx_cnt_q   <= HALF_RELOAD;
            rx_start_q <= 1'b1;
          end
        end
        RX_START: begin
          if (rx_cnt_q != 16'd0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else if (!rx_line) begin
            rx_state_q <= RX_DATA;
            rx_cnt_q   <= BIT_RELOAD;
            rx_idx_q   <= 3'd0;
          end else begin
            // Glitch shorter than half a bit: not a real start.
            rx_state_q <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (rx_cnt_q != 16'd0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else begin
            rx_shift_q <= {rx_line, rx_shift_q[7:1]};
            rx_cnt_q   <= BIT_RELOAD;
            if (rx_idx_q == 3'd7) rx_state_q <= RX_STOP;
            else                  rx_idx_q   <= rx_idx_q + 3'd1;
          end
        end
        RX_STOP: begin
          if (rx_cnt_q != 16'd0) begin
            rx_cnt_q <= rx_cnt_q - 16'd1;
          end else if (rx_line) begin
            rx_byte_q  <= rx_shift_q;
            rx_valid_q <= 1'b1;
            rx_state_q <= RX_IDLE;
          end else begin
            // Framing error: drop the byte and wait for the line to idle.
            rx_ferr_q  <= 1'b1;
            rx_state_q <= RX_WAIT_HIGH;
          end
        end
        RX_WAIT_HIGH: begin
          if (rx_line) rx_state_q <= RX_IDLE;
        end
        default: rx_state_q <= RX_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Command parser
  // ---------------------------------------------------------------------
  typedef enum logic [2:0] {
    P_IDLE, P_GET_DATA, P_DMI_ACC, P_DMI_CAP, P_SEND, P_HRST
  } p_state_t;

  p_state_t    p_state_q;
  logic [6:0]  addr_pend_q;
  logic [31:0] wdata_pend_q;
  logic        wr_pend_q;
  logic [1:0]  byte_cnt_q;
  logic        cap_phase_q;
  logic        q_load_q;
  logic [31:0] q_data_q;
  logic [2:0]  q_len_q;
  logic        dmi_en_q;
  logic        dmi_wr_q;
  logic [6:0]  dmi_addr_q;
  logic [31:0] dmi_wdata_q;
  logic        hrst_q;
  logic        tx_active_q;
  logic        tx_idle;
  logic        to_expired;

  assign tx_idle = !tx_active_q && !q_load_q;

`ifdef UART_DMI_TIMEOUT_EN
  logic [31:0] to_cnt_q;

  assign to_expired = (to_cnt_q >= 32'(TIMEOUT_CYCLES - 1));

  // Count idle cycles since the last start bit while a write frame is open.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      to_cnt_q <= '0;
    end else if (p_state_q != P_GET_DATA || rx_start_q) begin
      to_cnt_q <= '0;
    end else if (!to_expired) begin
      to_cnt_q <= to_cnt_q + 32'd1;
    end
  end
`else
  assign to_expired = 1'b0;
`endif

  // Parser FSM: decode commands, strobe the DMI port, queue the reply.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      p_state_q    <= P_IDLE;
      addr_pend_q  <= '0;
      wdata_pend_q <= '0;
      wr_pend_q    <= 1'b0;
      byte_cnt_q   <= '0;
      cap_phase_q  <= 1'b0;
      q_load_q     <= 1'b0;
      q_data_q     <= '0;
      q_len_q      <= '0;
      dmi_en_q     <= 1'b0;
      dmi_wr_q     <= 1'b0;
      dmi_addr_q   <= '0;
      dmi_wdata_q  <= '0;
      hrst_q       <= 1'b0;
    end else begin
      dmi_en_q <= 1'b0;
      dmi_wr_q <= 1'b0;
      hrst_q   <= 1'b0;
      q_load_q <= 1'b0;
      case (p_state_q)
        P_IDLE: begin
          if (rx_valid_q) begin
            addr_pend_q <= rx_byte_q[6:0];
            if (rx_byte_q == 8'hFF) begin
              p_state_q <= P_HRST;
            end else if (rx_byte_q[7]) begin
              byte_cnt_q <= 2'd0;
              p_state_q  <= P_GET_DATA;
            end else begin
              wr_pend_q <= 1'b0;
              p_state_q <= P_DMI_ACC;
            end
          end
        end
        P_GET_DATA: begin
          if (rx_ferr_q || to_expired) begin
            p_state_q <= P_IDLE;
          end else if (rx_valid_q) begin
            wdata_pend_q <= {rx_byte_q, wdata_pend_q[31:8]};
            if (byte_cnt_q == 2'd3) begin
              wr_pend_q <= 1'b1;
              p_state_q <= P_DMI_ACC;
            end else begin
              byte_cnt_q <= byte_cnt_q + 2'd1;
            end
          end
        end
        P_DMI_ACC: begin
          dmi_en_q    <= 1'b1;
          dmi_wr_q    <= wr_pend_q;
          dmi_addr_q  <= addr_pend_q;
          if (wr_pend_q) dmi_wdata_q <= wdata_pend_q;
          cap_phase_q <= 1'b0;
          p_state_q   <= P_DMI_CAP;
        end
        P_DMI_CAP: begin
          // First cycle is the strobe itself; read data is taken one later.
          if (!cap_phase_q) begin
            cap_phase_q <= 1'b1;
          end else begin
            q_load_q  <= 1'b1;
            q_data_q  <= wr_pend_q ? 32'h0 : i_dmi_reg_rdata;
            q_len_q   <= wr_pend_q ? 3'd1 : 3'd4;
            p_state_q <= P_SEND;
          end
        end
        P_HRST: begin
          hrst_q    <= 1'b1;
          q_load_q  <= 1'b1;
          q_data_q  <= 32'h0;
          q_len_q   <= 3'd1;
          p_state_q <= P_SEND;
        end
        P_SEND: begin
          if (tx_idle) p_state_q <= P_IDLE;
        end
        default: p_state_q <= P_IDLE;
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // UART transmitter: sends q_len bytes of q_data LSB byte first
  // ---------------------------------------------------------------------
  logic [31:0] tx_data_q;
  logic [2:0]  tx_left_q;
  logic [3:0]  tx_pos_q;
  logic [15:0] tx_cnt_q;
  logic        tx_q;

  // Bit position 0 is the start bit, 1..8 data, 9 stop; next byte follows at once.
  always_ff @(posedge clk or posedge rst_int) begin
    if (rst_int) begin
      tx_data_q   <= '0;
      tx_left_q   <= '0;
      tx_pos_q    <= '0;
      tx_cnt_q    <= '0;
      tx_active_q <= 1'b0;
      tx_q        <= 1'b1;
    end else if (q_load_q) begin
      tx_data_q   <= q_data_q;
      tx_left_q   <= q_len_q;
      tx_pos_q    <= 4'd0;
      tx_cnt_q    <= BIT_RELOAD;
      tx_active_q <= 1'b1;
      tx_q        <= 1'b0;
    end else if (tx_active_q) begin
      if (tx_cnt_q != 16'd0) begin
        tx_cnt_q <= tx_cnt_q - 16'd1;
      end else begin
        tx_cnt_q <= BIT_RELOAD;
        if (tx_pos_q == 4'd9) begin
          if (tx_left_q > 3'd1) begin
            tx_left_q <= tx_left_q - 3'd1;
            tx_data_q <= {8'h00, tx_data_q[31:8]};
            tx_pos_q  <= 4'd0;
            tx_q      <= 1'b0;
          end else begin
            tx_left_q   <= 3'd0;
            tx_active_q <= 1'b0;
            tx_q        <= 1'b1;
          end
        end else begin
          tx_pos_q <= tx_pos_q + 4'd1;
          tx_q     <= (tx_pos_q < 4'd8) ? tx_data_q[tx_pos_q[2:0]] : 1'b1;
        end
      end
    end
  end

  assign o_uart_tx        = tx_q;
  assign o_dmi_reg_en     = dmi_en_q;
  assign o_dmi_reg_addr   = dmi_addr_q;
  assign o_dmi_reg_wr_en  = dmi_wr_q;
  assign o_dmi_reg_wdata  = dmi_wdata_q;
  assign o_dmi_hard_reset = hrst_q;

endmodule
